// File: rtl/sdram_req_queue.sv
// Host-side request queue for the SDRAM controller: buffers host requests and
// replays each one as a row phase, a column phase and a one-cycle release.
module sdram_req_queue #(
    parameter int DEPTH      = 4,
    parameter int ROW_CYCLES = 3,
    parameter int TIMEOUT    = 64,
    parameter int ROW_W      = 13,
    parameter int COL_W      = 9,
    parameter int BANK_W     = 2,
    parameter int DATA_W     = 16
) (
    input  logic                       CLK,
    input  logic                       NRST,
    input  logic                       host_valid,
    output logic                       host_ready,
    input  logic                       host_we,
    input  logic [BANK_W-1:0]          host_bank,
    input  logic [ROW_W-1:0]           host_row,
    input  logic [COL_W-1:0]           host_col,
    input  logic [DATA_W-1:0]          host_wdata,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       err,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [ROW_W-1:0]           mc_adr,
    output logic [BANK_W-1:0]          mc_bdr,
    output logic [DATA_W-1:0]          mc_din,
    output logic                       mc_re,
    output logic                       mc_we,
    input  logic                       mc_rdy,
    input  logic [DATA_W-1:0]          mc_dout,
    output logic [1:0]                 dbg_state
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int CYC_MAX = (TIMEOUT > ROW_CYCLES) ? TIMEOUT : ROW_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX) + 1;

    typedef struct packed {
        logic              we;
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROW  = 2'd1,
        COL  = 2'd2,
        DONE = 2'd3
    } state_t;

    req_t              mem_q [DEPTH];
    req_t              req_in;
    req_t              head;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop;

    state_t            state_q;
    logic [CYC_W-1:0]  cyc_q;
    logic              work_we_q;
    logic [COL_W-1:0]  work_col_q;
    logic [ROW_W-1:0]  mc_adr_q;
    logic [BANK_W-1:0] mc_bdr_q;
    logic [DATA_W-1:0] mc_din_q;
    logic              mc_re_q, mc_we_q;
    logic              rd_valid_q, err_q;
    logic [DATA_W-1:0] rd_data_q;

    // Handshake: a request transfers on any rising edge where host_valid && host_ready;
    // host_ready looks only at the registered count, so a same-cycle pop never frees a slot early.
    assign host_ready = (count_q < CW'(DEPTH));
    assign push       = host_valid && host_ready;
    assign pop        = (state_q == DONE);
    assign req_in     = '{we: host_we, bank: host_bank, row: host_row, col: host_col, wdata: host_wdata};
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= req_in;
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Strobes and address change on the same edge as the state, so DONE and IDLE
    // always present two strobe-free cycles between requests.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            work_we_q  <= 1'b0;
            work_col_q <= '0;
            mc_adr_q   <= '0;
            mc_bdr_q   <= '0;
            mc_din_q   <= '0;
            mc_re_q    <= 1'b0;
            mc_we_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        work_we_q  <= head.we;
                        work_col_q <= head.col;
                        mc_re_q    <= !head.we;
                        mc_we_q    <= head.we;
                        mc_bdr_q   <= head.bank;
                        mc_adr_q   <= head.row;
                        mc_din_q   <= head.wdata;
                        cyc_q      <= '0;
                        state_q    <= ROW;
                    end
                end
                ROW: begin
                    if (cyc_q == CYC_W'(ROW_CYCLES - 1)) begin
                        mc_adr_q <= ROW_W'(work_col_q);
                        cyc_q    <= '0;
                        state_q  <= COL;
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                COL: begin
                    if (mc_rdy) begin
                        mc_re_q <= 1'b0;
                        mc_we_q <= 1'b0;
                        state_q <= DONE;
                        if (!work_we_q) begin
                            rd_data_q  <= mc_dout;
                            rd_valid_q <= 1'b1;
                        end
                    end else if (cyc_q == CYC_W'(TIMEOUT - 1)) begin
                        mc_re_q <= 1'b0;
                        mc_we_q <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mc_adr     = mc_adr_q;
    assign mc_bdr     = mc_bdr_q;
    assign mc_din     = mc_din_q;
    assign mc_re      = mc_re_q;
    assign mc_we      = mc_we_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign err        = err_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign dbg_state  = state_q;

endmodule
